// File: rtl/spi_frame_decoder.sv
// SPI slave that decodes {cmd, memory_code, address} headers followed by data words
// into one-clk memory write/read strobes, with burst addressing in both directions.
module spi_frame_decoder #(
    parameter int CODE_BIT_WIDTH          = 4,
    parameter int START_ADDRESS_BIT_WIDTH = 14,
    parameter int MESSAGE_BIT_WIDTH       = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sck,
    input  logic                               cs_n,
    input  logic                               mosi,
    output logic                               miso,
    output logic                               program_memory_new,
    output logic                               read_memory_sync,
    output logic [CODE_BIT_WIDTH-1:0]          memory_code,
    output logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address,
    output logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in,
    input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out
);

    localparam int HEADER_BITS = 2 + CODE_BIT_WIDTH + START_ADDRESS_BIT_WIDTH;
    localparam int RX_W        = (HEADER_BITS > MESSAGE_BIT_WIDTH) ? HEADER_BITS : MESSAGE_BIT_WIDTH;
    localparam int CNT_W       = $clog2(RX_W + 1);
    localparam int AW          = START_ADDRESS_BIT_WIDTH;
    localparam int MW          = MESSAGE_BIT_WIDTH;

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HEADER_BITS - 1);
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    ADDR_ONE = AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        WRITE_DATA,
        READ_ISSUE,
        READ_CAPTURE,
        READ_SHIFT,
        IGNORE
    } state_t;

    state_t state_q, state_d;

    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic sck_meta_d, sck_sync_d, sck_prev_d;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic cs_meta_d, cs_sync_d, cs_prev_d;
    logic mosi_meta_q, mosi_sync_q;
    logic mosi_meta_d, mosi_sync_d;
    logic [1:0] sync_valid_q, sync_valid_d;
    logic armed_q, armed_d;

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [RX_W-1:0]  rx_shift_q, rx_shift_d;
    logic [MW-1:0]    tx_shift_q, tx_shift_d;

    logic                      miso_q, miso_d;
    logic                      program_memory_new_q, program_memory_new_d;
    logic                      read_memory_sync_q, read_memory_sync_d;
    logic [CODE_BIT_WIDTH-1:0] memory_code_q, memory_code_d;
    logic [AW-1:0]             spi_address_q, spi_address_d;
    logic [MW-1:0]             spi_data_in_q, spi_data_in_d;

    logic                   sck_rise, sck_fall, cs_fall, cs_rise;
    logic [HEADER_BITS-1:0] hdr_word;
    logic [MW-1:0]          data_word;
    logic [RX_W-1:0]        rx_shifted;

    // A falling cs_n only counts once a genuine high level has been seen after reset,
    // so a frame that was already running when reset hit is ignored to its end.
    assign sck_rise = sck_sync_q & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q & sck_prev_q;
    assign cs_fall  = ~cs_sync_q & cs_prev_q & armed_q;
    assign cs_rise  = cs_sync_q & ~cs_prev_q;

    assign rx_shifted = {rx_shift_q[RX_W-2:0], mosi_sync_q};
    assign hdr_word   = rx_shifted[HEADER_BITS-1:0];
    assign data_word  = rx_shifted[MW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= IDLE;
            sck_meta_q           <= 1'b0;
            sck_sync_q           <= 1'b0;
            sck_prev_q           <= 1'b0;
            cs_meta_q            <= 1'b1;
            cs_sync_q            <= 1'b1;
            cs_prev_q            <= 1'b1;
            mosi_meta_q          <= 1'b0;
            mosi_sync_q          <= 1'b0;
            sync_valid_q         <= '0;
            armed_q              <= 1'b0;
            bit_cnt_q            <= '0;
            rx_shift_q           <= '0;
            tx_shift_q           <= '0;
            miso_q               <= 1'b0;
            program_memory_new_q <= 1'b0;
            read_memory_sync_q   <= 1'b0;
            memory_code_q        <= '0;
            spi_address_q        <= '0;
            spi_data_in_q        <= '0;
        end else begin
            state_q              <= state_d;
            sck_meta_q           <= sck_meta_d;
            sck_sync_q           <= sck_sync_d;
            sck_prev_q           <= sck_prev_d;
            cs_meta_q            <= cs_meta_d;
            cs_sync_q            <= cs_sync_d;
            cs_prev_q            <= cs_prev_d;
            mosi_meta_q          <= mosi_meta_d;
            mosi_sync_q          <= mosi_sync_d;
            sync_valid_q         <= sync_valid_d;
            armed_q              <= armed_d;
            bit_cnt_q            <= bit_cnt_d;
            rx_shift_q           <= rx_shift_d;
            tx_shift_q           <= tx_shift_d;
            miso_q               <= miso_d;
            program_memory_new_q <= program_memory_new_d;
            read_memory_sync_q   <= read_memory_sync_d;
            memory_code_q        <= memory_code_d;
            spi_address_q        <= spi_address_d;
            spi_data_in_q        <= spi_data_in_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        sck_meta_d           = sck;
        sck_sync_d           = sck_meta_q;
        sck_prev_d           = sck_sync_q;
        cs_meta_d            = cs_n;
        cs_sync_d            = cs_meta_q;
        cs_prev_d            = cs_sync_q;
        mosi_meta_d          = mosi;
        mosi_sync_d          = mosi_meta_q;
        sync_valid_d         = {sync_valid_q[0], 1'b1};
        armed_d              = armed_q | (sync_valid_q[1] & cs_sync_q);
        bit_cnt_d            = bit_cnt_q;
        rx_shift_d           = rx_shift_q;
        tx_shift_d           = tx_shift_q;
        program_memory_new_d = 1'b0;
        memory_code_d        = memory_code_q;
        spi_address_d        = spi_address_q;
        spi_data_in_d        = spi_data_in_q;

        // Burst writes advance the address on the clk after each strobe.
        if (program_memory_new_q) begin
            spi_address_d = spi_address_q + ADDR_ONE;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = HEADER;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end
            end
            HEADER: begin
                if (sck_rise) begin
                    rx_shift_d = rx_shifted;
                    bit_cnt_d  = bit_cnt_q + CNT_ONE;
                    if (bit_cnt_q == HDR_LAST) begin
                        bit_cnt_d = '0;
                        if (hdr_word[HEADER_BITS-1 -: 2] == 2'b01) begin
                            state_d       = WRITE_DATA;
                            memory_code_d = hdr_word[AW +: CODE_BIT_WIDTH];
                            spi_address_d = hdr_word[AW-1:0];
                        end else if (hdr_word[HEADER_BITS-1 -: 2] == 2'b10) begin
                            state_d       = READ_ISSUE;
                            memory_code_d = hdr_word[AW +: CODE_BIT_WIDTH];
                            spi_address_d = hdr_word[AW-1:0];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
            end
            WRITE_DATA: begin
                if (sck_rise) begin
                    rx_shift_d = rx_shifted;
                    bit_cnt_d  = bit_cnt_q + CNT_ONE;
                    if (bit_cnt_q == MSG_LAST) begin
                        bit_cnt_d            = '0;
                        spi_data_in_d        = data_word;
                        program_memory_new_d = 1'b1;
                    end
                end
            end
            READ_ISSUE: begin
                state_d = READ_CAPTURE;
            end
            READ_CAPTURE: begin
                tx_shift_d = spi_data_out;
                bit_cnt_d  = '0;
                state_d    = READ_SHIFT;
            end
            READ_SHIFT: begin
                // The MSB is already on miso, so the first fall of a word must not shift.
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                    if (bit_cnt_q == MSG_LAST) begin
                        bit_cnt_d     = '0;
                        spi_address_d = spi_address_q + ADDR_ONE;
                        state_d       = READ_ISSUE;
                    end
                end else if (sck_fall && (bit_cnt_q != '0)) begin
                    tx_shift_d = {tx_shift_q[MW-2:0], 1'b0};
                end
            end
            IGNORE: begin
                state_d = IGNORE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && cs_rise) begin
            state_d = IDLE;
        end

        read_memory_sync_d = (state_d == READ_ISSUE);
        miso_d             = (state_d == READ_SHIFT) ? tx_shift_d[MW-1] : 1'b0;
    end

    assign miso               = miso_q;
    assign program_memory_new = program_memory_new_q;
    assign read_memory_sync   = read_memory_sync_q;
    assign memory_code        = memory_code_q;
    assign spi_address        = spi_address_q;
    assign spi_data_in        = spi_data_in_q;

endmodule

// File: doc/spi_frame_decoder.md
SPI_FRAME_DECODER -- requirements
Module: spi_frame_decoder

Interface
REQ-001 SHALL have parameter CODE_BIT_WIDTH, default 4, meaning width of the target-memory code field.
REQ-002 SHALL have parameter START_ADDRESS_BIT_WIDTH, default 14, meaning width of the message-granular address field.
REQ-003 SHALL have parameter MESSAGE_BIT_WIDTH, default 32, meaning width of one data message.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port sck, input, 1, meaning SPI clock from the host, asynchronous to clk.
REQ-007 SHALL have port cs_n, input, 1, meaning SPI chip select, active-low, asynchronous to clk.
REQ-008 SHALL have port mosi, input, 1, meaning SPI data from the host.
REQ-009 SHALL have port miso, output, 1, meaning SPI data to the host.
REQ-010 SHALL have port program_memory_new, output, 1, meaning a one-clk write strobe.
REQ-011 SHALL have port read_memory_sync, output, 1, meaning a one-clk read strobe.
REQ-012 SHALL have port memory_code, output, CODE_BIT_WIDTH, meaning the target-memory selector.
REQ-013 SHALL have port spi_address, output, START_ADDRESS_BIT_WIDTH, meaning the message address.
REQ-014 SHALL have port spi_data_in, output, MESSAGE_BIT_WIDTH, meaning the message to write.
REQ-015 SHALL have port spi_data_out, input, MESSAGE_BIT_WIDTH, meaning read data, valid one clk after read_memory_sync.

Function
REQ-016 SHALL pass sck, cs_n and mosi through 2-FF synchronizers, then detect sck rising and falling edges on the synchronized signal; legal sck frequency is at most clk/8.
REQ-017 SHALL accept frames MSB-first, mosi sampled on sck rise: header = cmd[1:0], memory_code, address (20 bits at defaults), then a data phase.
REQ-018 SHALL decode cmd as follows: 01 = write, 10 = read, 00/11 = invalid.
REQ-019 SHALL implement FSM states IDLE, HEADER, WRITE_DATA, READ_ISSUE, READ_CAPTURE, READ_SHIFT, IGNORE.
REQ-020 SHALL move IDLE->HEADER on synchronized cs_n falling, clearing the bit counter.
REQ-021 SHALL, when the last header bit is sampled, move HEADER->WRITE_DATA for cmd 01, HEADER->READ_ISSUE for cmd 10, and HEADER->IGNORE otherwise; memory_code and spi_address SHALL be updated at this point only.
REQ-022 SHALL, in WRITE_DATA, shift MESSAGE_BIT_WIDTH bits, then load spi_data_in and assert program_memory_new for exactly 1 clk; from the clk after the pulse, spi_address SHALL increment, wrapping modulo 2^START_ADDRESS_BIT_WIDTH, and the FSM SHALL stay in WRITE_DATA (burst).
REQ-023 SHALL, in READ_ISSUE, assert read_memory_sync for 1 clk and then go to READ_CAPTURE.
REQ-024 SHALL, in READ_CAPTURE, latch spi_data_out into the transmit shifter, drive its MSB on miso, and then go to READ_SHIFT.
REQ-025 SHALL, in READ_SHIFT, shift the next bit onto miso on each sck fall; after MESSAGE_BIT_WIDTH sck rises it SHALL increment spi_address (with wrap) and return to READ_ISSUE, so the next word is on miso before the following sck fall.
REQ-026 SHALL hold miso at 0 outside READ_CAPTURE/READ_SHIFT.
REQ-027 SHALL, in IGNORE, produce no strobes and leave all outputs unchanged until cs_n rises.
REQ-028 SHALL, on synchronized cs_n rise in any state, go to IDLE within 1 clk; a partial header or partial data word SHALL be discarded with no strobe, and address, data and code outputs SHALL hold their last values.
REQ-029 SHALL assert program_memory_new within 4 clk of the pin-level sck rise that carries the last data bit.
REQ-030 SHALL never assert program_memory_new and read_memory_sync in the same clk.

Reset
REQ-031 SHALL, while rst is high, force the FSM to IDLE, all synchronizers to idle levels (cs_n=1, sck=0), and counters and shifters to 0.
REQ-032 SHALL drive miso, program_memory_new, read_memory_sync, memory_code, spi_address and spi_data_in to 0 while rst is high.
REQ-033 SHALL, if rst is asserted mid-frame, start decoding only at the next cs_n falling edge, because the remainder of that frame is ignored.

Verification
REQ-034 SHALL cover single write: cmd 01, code 3, addr 0x0005, data 0xDEADBEEF -> one program_memory_new pulse with memory_code=3, spi_address=5, spi_data_in=0xDEADBEEF.
REQ-035 SHALL cover burst write: 3 words to addr 0x3FFF -> strobes at addresses 0x3FFF, 0x0000, 0x0001.
REQ-036 SHALL cover burst read: cmd 10, addr 0x10, memory model returning addr*0x01010101 -> miso streams 0x10101010 then 0x11111111, with read strobes at 0x10 and 0x11.
REQ-037 SHALL cover abort: cs_n raised after 40 of 52 bits -> no strobe, FSM in IDLE, and the next valid frame decodes correctly.
REQ-038 SHALL cover invalid opcode: cmd 11 followed by 32 data bits -> no strobes and miso=0 throughout.
REQ-039 SHALL cover reset mid-read: rst pulsed during READ_SHIFT -> all outputs 0, and a following write frame behaves as in REQ-034.
